conv55_window_gen: RTL and testbench

Streaming 5x5 window generator that sits directly upstream of the LeNet-5 5x5 convolution block. It accepts a raster-order stream of 8-bit pixels and buffers four previous image rows in line buffers. For every valid 5x5 neighbourhood it presents all 25 pixels in parallel, in the order the convolution block's in_data_0..in_data_24 inputs expect. The output is registered, with a valid/ready handshake and backpressure to the pixel source.

---
 rtl/conv55_window_gen_if.sv | 55 +++++
 rtl/conv55_window_gen.sv | 175 +++++++++++++++++
 tb/tb_conv55_window_gen.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv55_window_gen_if.sv
// -----------------------------------------------------------------------------
// conv55_window_gen_if
// Handshake bundle between a raster pixel source, the 5x5 window generator and
// the downstream 5x5 convolution block.
//
// Signals:
//   in_valid   : pixel present on in_data
//   in_ready   : window generator can accept a pixel
//   in_sof     : qualifies in_data as pixel (0,0) of a new frame
//   in_data    : 8-bit unsigned pixel
//   win_valid  : window present on win_data
//   win_ready  : downstream consumes the window
//   win_data   : 25 bytes, byte k = win_data[8k+7:8k], k = 5*wr + wc
//   win_last   : window is the last one of the frame
//   frame_done : one-cycle pulse after the last pixel of a frame is accepted
//
// Modports:
//   master : pixel source / window sink side (drives pixels and win_ready)
//   slave  : window generator side
// -----------------------------------------------------------------------------
interface conv55_window_gen_if;
   logic         in_valid;
   logic         in_ready;
   logic         in_sof;
   logic [7:0]   in_data;
   logic         win_valid;
   logic         win_ready;
   logic [199:0] win_data;
   logic         win_last;
   logic         frame_done;

   modport master (
      output in_valid,
      output in_sof,
      output in_data,
      output win_ready,
      input  in_ready,
      input  win_valid,
      input  win_data,
      input  win_last,
      input  frame_done
   );

   modport slave (
      input  in_valid,
      input  in_sof,
      input  in_data,
      input  win_ready,
      output in_ready,
      output win_valid,
      output win_data,
      output win_last,
      output frame_done
   );
endinterface

// File: rtl/conv55_window_gen.sv
// -----------------------------------------------------------------------------
// conv55_window_gen
// Streaming 5x5 window generator feeding the LeNet-5 5x5 convolution block.
// Raster-order 8-bit pixels come in; four line buffers keep the previous four
// rows, and a 5x5 shift array holds the current neighbourhood. For every pixel
// at row>=4, col>=4 the full 5x5 neighbourhood ending at that pixel is placed
// in a single output register with a valid/ready handshake.
//
// Parameters:
//   IMG_W : image width in pixels  (>=5)
//   IMG_H : image height in rows   (>=5)
//
// Ports:
//   clk : clock, all state on rising edge
//   rst : asynchronous active-high reset
//   bus : conv55_window_gen_if.slave
//         in_valid/in_ready/in_sof/in_data      pixel input
//         win_valid/win_ready/win_data/win_last window output
//         frame_done                            end-of-frame pulse
//
// Window layout: byte k = 5*wr + wc holds pixel(row-4+wr, col-4+wc), where
// (row,col) is the position of the pixel that produced the window.
// -----------------------------------------------------------------------------
module conv55_window_gen #(
   parameter int IMG_W = 32,
   parameter int IMG_H = 32
) (
   input logic                 clk,
   input logic                 rst,
   conv55_window_gen_if.slave  bus
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   // position counters: location of the next pixel to be accepted
   logic [CW-1:0]  col_q;
   logic [CW-1:0]  col_d;
   logic [RW-1:0]  row_q;
   logic [RW-1:0]  row_d;

   // position of the pixel currently presented (in_sof forces (0,0))
   logic [CW-1:0]  pos_col;
   logic [RW-1:0]  pos_row;

   logic           accept;
   logic           at_row_end;
   logic           at_last;
   logic           produce;

   // line buffers, one 32-bit word per column: {LB3, LB2, LB1, LB0}
   logic [31:0]    lb_q [IMG_W];
   logic [31:0]    lb_rd;

   // incoming window column, byte wr = row (row-4+wr) at the current column
   logic [39:0]    new_col;

   // 5x5 shift array and its next state (same byte layout as win_data)
   logic [199:0]   win_q;
   logic [199:0]   win_next;

   // output register
   logic [199:0]   win_data_q;
   logic           win_valid_q;
   logic           win_valid_d;
   logic           win_last_q;
   logic           frame_done_q;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   // The output register is the only buffering, so a pixel can only be
   // taken when the register is empty or being drained this cycle.
   assign bus.in_ready = !win_valid_q || bus.win_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   // ------------------------------------------------------------------
   // Position tracking
   // ------------------------------------------------------------------
   assign pos_col    = bus.in_sof ? '0 : col_q;
   assign pos_row    = bus.in_sof ? '0 : row_q;
   assign at_row_end = (pos_col == CW'(IMG_W - 1));
   assign at_last    = at_row_end && (pos_row == RW'(IMG_H - 1));
   assign produce    = accept && (pos_row >= RW'(4)) && (pos_col >= CW'(4));

   always_comb begin
      col_d = pos_col + 1'b1;
      row_d = pos_row;
      if (at_row_end) begin
         col_d = '0;
         if (at_last) begin
            row_d = '0;
         end else begin
            row_d = pos_row + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Line buffers
   // ------------------------------------------------------------------
   // The read happens in the same cycle as the write to the same column, so
   // the read sees the pre-update contents: LB0 = row-1 ... LB3 = row-4.
   // Contents need no reset: every column is rewritten by rows 0..3 of a
   // frame before a window at row 4 can read it.
   assign lb_rd = lb_q[pos_col];

   always_ff @(posedge clk) begin
      if (accept) begin
         lb_q[pos_col] <= {lb_rd[23:0], bus.in_data};
      end
   end

   // oldest row at byte 0, the incoming pixel at byte 4
   assign new_col = {bus.in_data, lb_rd[7:0], lb_rd[15:8], lb_rd[23:16], lb_rd[31:24]};

   // ------------------------------------------------------------------
   // Window shift: each row of the array shifts one column left and the
   // fresh column enters at wc = 4. Stale columns from the previous image
   // row are pushed out during cols 0..3, before any window is emitted.
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 25; gi++) begin : g_win
         if ((gi % 5) == 4) begin : g_new
            assign win_next[8*gi +: 8] = new_col[8*(gi/5) +: 8];
         end else begin : g_shift
            assign win_next[8*gi +: 8] = win_q[8*(gi+1) +: 8];
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Output valid: a newly produced window always wins over draining, so a
   // simultaneous handshake and load keeps win_valid high with no bubble.
   // ------------------------------------------------------------------
   always_comb begin
      win_valid_d = win_valid_q;
      if (produce) begin
         win_valid_d = 1'b1;
      end else if (bus.win_ready) begin
         win_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         win_q        <= '0;
         win_data_q   <= '0;
         win_valid_q  <= 1'b0;
         win_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         if (accept) begin
            col_q <= col_d;
            row_q <= row_d;
            win_q <= win_next;
         end
         if (produce) begin
            win_data_q <= win_next;
            win_last_q <= at_last;
         end
         win_valid_q  <= win_valid_d;
         // an in_sof pixel is never "last", so a truncated frame never pulses
         frame_done_q <= accept && at_last;
      end
   end

   assign bus.win_valid  = win_valid_q;
   assign bus.win_data   = win_data_q;
   assign bus.win_last   = win_last_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv55_window_gen.sv
// -----------------------------------------------------------------------------
// tb_conv55_window_gen
// Scoreboard bench for conv55_window_gen. The stimulus side keeps an image
// array of the current frame; each accepted pixel at row>=4, col>=4 pushes the
// 5x5 neighbourhood read straight out of that image. A separate monitor pops
// and compares on every output handshake, and also watches stall stability,
// in_ready during stalls and frame_done alignment. A second 5x5 instance is
// exercised directly.
// -----------------------------------------------------------------------------
module tb_conv55_window_gen;
   localparam int W = 32;
   localparam int H = 32;

   typedef struct {
      logic [199:0] data;
      logic         last;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   conv55_window_gen_if bus_if ();
   conv55_window_gen_if bus5_if ();

   conv55_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   conv55_window_gen #(.IMG_W(5), .IMG_H(5)) dut5 (
      .clk (clk),
      .rst (rst),
      .bus (bus5_if)
   );

   int           checks   = 0;
   int           errors   = 0;
   int           fd_seen  = 0;
   int           win_seen = 0;
   bit           rdy_random = 1'b0;
   exp_t         exp_q [$];

   // reference model state: current frame image and next pixel position
   logic [7:0]   img [H][W];
   int           mr = 0;
   int           mc = 0;

   logic         stall_prev = 1'b0;
   logic [199:0] prev_data  = '0;
   logic         prev_last  = 1'b0;

   task automatic chk(input string name, input logic [199:0] act, input logic [199:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // model: a pixel was accepted; record it and emit the expected window
   task automatic model_accept(input logic [7:0] d, input bit sof);
      exp_t e;
      if (sof) begin
         mr = 0;
         mc = 0;
      end
      img[mr][mc] = d;
      if (mr >= 4 && mc >= 4) begin
         for (int wr = 0; wr < 5; wr++) begin
            for (int wc = 0; wc < 5; wc++) begin
               e.data[8*(5*wr+wc) +: 8] = img[mr-4+wr][mc-4+wc];
            end
         end
         e.last = (mr == H-1) && (mc == W-1);
         exp_q.push_back(e);
      end
      mc++;
      if (mc == W) begin
         mc = 0;
         mr++;
         if (mr == H) mr = 0;
      end
   endtask

   // called just after a rising edge; returns just after the accepting edge
   task automatic send_pixel(input logic [7:0] d, input bit sof, input bit gaps);
      int waited;
      if (gaps) begin
         while ($urandom_range(0, 3) == 0) begin
            bus_if.in_valid = 1'b0;
            bus_if.in_sof   = 1'($urandom_range(0, 1));
            bus_if.in_data  = 8'($urandom);
            @(posedge clk);
            #1;
         end
      end
      bus_if.in_valid = 1'b1;
      bus_if.in_sof   = sof;
      bus_if.in_data  = d;
      waited = 0;
      forever begin
         @(negedge clk);
         if (bus_if.in_ready === 1'b1) begin
            model_accept(d, sof);
            @(posedge clk);
            #1;
            break;
         end
         @(posedge clk);
         #1;
         waited++;
         if (waited > 2000) begin
            $display("FAIL send_timeout: in_ready low for %0d cycles, required at most 2000", waited);
            errors++;
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "pixel source stuck");
         end
      end
   endtask

   task automatic send_frame(input bit rnd, input int rows, input bit use_sof, input bit gaps);
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < W; c++) begin
            send_pixel(rnd ? 8'($urandom) : 8'((32*r + c) % 256),
                       use_sof && (r == 0) && (c == 0), gaps);
         end
      end
      bus_if.in_valid = 1'b0;
      bus_if.in_sof   = 1'b0;
   endtask

   task automatic finish_phase(input string name, input int exp_windows, input int exp_fd_total);
      for (int i = 0; i < 3000 && (exp_q.size() != 0 || bus_if.win_valid === 1'b1); i++) begin
         @(posedge clk);
         #2;
      end
      repeat (3) @(posedge clk);
      #2;
      chk({name, "_drain"}, 200'(exp_q.size()), 200'(0));
      chk({name, "_window_count"}, 200'(win_seen), 200'(exp_windows));
      chk({name, "_frame_done_count"}, 200'(fd_seen), 200'(exp_fd_total));
      $display("phase %s: windows %0d frame_done total %0d", name, win_seen, fd_seen);
      win_seen = 0;
   endtask

   // win_ready driver
   initial begin
      forever begin
         @(posedge clk);
         #1;
         bus_if.win_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // monitor / scoreboard checker
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               checks++;
               if (bus_if.win_valid !== 1'b1 || bus_if.win_data !== prev_data || bus_if.win_last !== prev_last) begin
                  errors++;
                  $display("FAIL stall_hold: valid=%0b last=%0b data=%h required valid=1 last=%0b data=%h",
                           bus_if.win_valid, bus_if.win_last, bus_if.win_data, prev_last, prev_data);
               end
            end
            if (bus_if.win_valid === 1'b1 && bus_if.win_ready === 1'b0) begin
               checks++;
               if (bus_if.in_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL in_ready_stall: in_ready=%0b required 0", bus_if.in_ready);
               end
            end
            if (bus_if.win_valid === 1'b1 && bus_if.win_ready === 1'b1) begin
               win_seen++;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_window: got data=%h last=%0b required no window",
                           bus_if.win_data, bus_if.win_last);
               end else begin
                  e = exp_q.pop_front();
                  if (bus_if.win_data !== e.data || bus_if.win_last !== e.last) begin
                     errors++;
                     $display("FAIL window: got last=%0b data=%h required last=%0b data=%h",
                              bus_if.win_last, bus_if.win_data, e.last, e.data);
                  end
               end
            end
            if (bus_if.frame_done === 1'b1) begin
               fd_seen++;
               checks++;
               if (bus_if.win_valid !== 1'b1 || bus_if.win_last !== 1'b1) begin
                  errors++;
                  $display("FAIL frame_done_align: win_valid=%0b win_last=%0b required 1 1",
                           bus_if.win_valid, bus_if.win_last);
               end
            end
            stall_prev = (bus_if.win_valid === 1'b1) && (bus_if.win_ready === 1'b0);
            prev_data  = bus_if.win_data;
            prev_last  = bus_if.win_last;
         end
      end
   end

   initial begin
      logic [7:0]   px5 [25];
      logic [199:0] exp5;
      int           r;
      int           c;

      rst               = 1'b1;
      bus_if.in_valid   = 1'b0;
      bus_if.in_sof     = 1'b0;
      bus_if.in_data    = '0;
      bus_if.win_ready  = 1'b1;
      bus5_if.in_valid  = 1'b0;
      bus5_if.in_sof    = 1'b0;
      bus5_if.in_data   = '0;
      bus5_if.win_ready = 1'b1;

      // reset state
      #1;
      chk("rst_win_valid", 200'(bus_if.win_valid), 200'(0));
      chk("rst_win_data", bus_if.win_data, 200'(0));
      chk("rst_win_last", 200'(bus_if.win_last), 200'(0));
      chk("rst_frame_done", 200'(bus_if.frame_done), 200'(0));
      chk("rst_in_ready", 200'(bus_if.in_ready), 200'(1));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // A: ramp frame, full throughput
      rdy_random = 1'b0;
      send_frame(1'b0, H, 1'b1, 1'b0);
      finish_phase("ramp", 784, 1);

      // B: same frame with random backpressure and source gaps
      rdy_random = 1'b1;
      @(posedge clk);
      #1;
      send_frame(1'b0, H, 1'b1, 1'b1);
      finish_phase("ramp_bp", 784, 2);

      // C: two random frames back to back, no gaps
      rdy_random = 1'b0;
      @(posedge clk);
      #1;
      send_frame(1'b1, H, 1'b1, 1'b0);
      send_frame(1'b1, H, 1'b1, 1'b0);
      finish_phase("b2b", 1568, 4);

      // D: 10 rows, then a new frame via in_sof (6*28 + 784 windows)
      rdy_random = 1'b1;
      @(posedge clk);
      #1;
      send_frame(1'b1, 10, 1'b1, 1'b1);
      send_frame(1'b1, H, 1'b1, 1'b1);
      finish_phase("sof_abort", 952, 5);

      // E: reset right after the window of pixel (6,10) is loaded
      @(posedge clk);
      #1;
      r = 0;
      c = 0;
      while (!(r == 6 && c == 11)) begin
         send_pixel(8'($urandom), (r == 0) && (c == 0), 1'b1);
         c++;
         if (c == W) begin
            c = 0;
            r++;
         end
      end
      chk("pre_rst_win_valid", 200'(bus_if.win_valid), 200'(1));
      rst = 1'b1;
      #1;
      chk("midrst_win_valid", 200'(bus_if.win_valid), 200'(0));
      chk("midrst_win_last", 200'(bus_if.win_last), 200'(0));
      chk("midrst_in_ready", 200'(bus_if.in_ready), 200'(1));
      exp_q.delete();
      mr = 0;
      mc = 0;
      bus_if.in_valid = 1'b0;
      bus_if.in_sof   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      send_frame(1'b1, H, 1'b0, 1'b1);
      finish_phase("midrst", 56 + 6 + 784, 6);

      // F: 5x5 image, exactly one window equal to the input pixels
      rdy_random = 1'b0;
      exp5 = '0;
      for (int i = 0; i < 25; i++) begin
         px5[i] = 8'($urandom);
         exp5[8*i +: 8] = px5[i];
         bus5_if.in_valid = 1'b1;
         bus5_if.in_sof   = (i == 0);
         bus5_if.in_data  = px5[i];
         @(posedge clk);
         #1;
         if (i < 24) begin
            chk("w5_no_early_window", 200'(bus5_if.win_valid), 200'(0));
         end
      end
      bus5_if.in_valid = 1'b0;
      bus5_if.in_sof   = 1'b0;
      chk("w5_win_valid", 200'(bus5_if.win_valid), 200'(1));
      chk("w5_win_data", bus5_if.win_data, exp5);
      chk("w5_win_last", 200'(bus5_if.win_last), 200'(1));
      chk("w5_frame_done", 200'(bus5_if.frame_done), 200'(1));
      @(posedge clk);
      #1;
      chk("w5_win_valid_clear", 200'(bus5_if.win_valid), 200'(0));
      chk("w5_frame_done_clear", 200'(bus5_if.frame_done), 200'(0));
      $display("phase w5: single window checked");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
